// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: operation codes and the
// default interrupt vector (used when PC_UNIT_INTR_EN is defined).
package pc_unit_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_JMP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_INTR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } pc_op_e;

    localparam logic [31:0] DEFAULT_INTR_VEC = 32'h0000_03FF;

endpackage

// File: rtl/pc_unit_if.sv
// Operation/status bundle between a sequencer (master) and pc_unit (slave).
// No handshake: one op is presented per cycle and takes effect at the next rising edge.
interface pc_unit_if #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [2:0]    pc_op;
    logic [AW-1:0] from_immed;
    logic          stk_err_clr;
    logic [AW-1:0] pc_count;
    logic [LW-1:0] stk_level;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;

    modport master (
        output pc_op, from_immed, stk_err_clr,
        input  pc_count, stk_level, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  pc_op, from_immed, stk_err_clr,
        output pc_count, stk_level, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack; the level doubles as the write pointer and only it is reset.
module pc_ret_stack #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              din,
    output logic [AW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] top_idx;

    assign wr_idx  = level[PW-1:0];
    assign top_idx = PW'(level - LW'(1));
    assign dout    = mem[top_idx];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (push) begin
            level <= level + LW'(1);
        end else if (pop) begin
            level <= level - LW'(1);
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Program counter with call/return stack and sticky stack-error flag.
// Define PC_UNIT_INTR_EN to enable op 5 (INTR); otherwise it acts as HOLD.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 8
`ifdef PC_UNIT_INTR_EN
    ,
    parameter logic [AW-1:0] INTR_VEC = AW'(DEFAULT_INTR_VEC)
`endif
) (
    input  logic    clk,
    input  logic    rst_n,
    pc_unit_if.slave bus
);
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] push_data;
    logic [AW-1:0] top_data;
    logic          push;
    logic          pop;
    logic          err_set;
    logic          err;
    logic          full;
    logic          empty;
    pc_op_e        op;

    assign op       = pc_op_e'(bus.pc_op);
    assign pc_plus1 = pc + AW'(1);

    always_comb begin
        pc_next   = pc;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        push_data = pc_plus1;
        case (op)
            OP_INC:  pc_next = pc_plus1;
            OP_JMP:  pc_next = bus.from_immed;
            OP_CALL: begin
                if (full) begin
                    err_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = bus.from_immed;
                end
            end
            OP_RET: begin
                if (empty) begin
                    err_set = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = top_data;
                end
            end
`ifdef PC_UNIT_INTR_EN
            // Interrupts save the current PC so the interrupted op is resumed.
            OP_INTR: begin
                if (full) begin
                    err_set = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_data = pc;
                    pc_next   = INTR_VEC;
                end
            end
`endif
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= '0;
            err <= 1'b0;
        end else begin
            pc <= pc_next;
            // A fresh error beats a simultaneous clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (bus.stk_err_clr) begin
                err <= 1'b0;
            end
        end
    end

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (top_data),
        .level (bus.stk_level),
        .full  (full),
        .empty (empty)
    );

    assign bus.pc_count  = pc;
    assign bus.stk_err   = err;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed table, hand-written corner sequences and random ops
// checked against a queue-based model of the return stack.
module tb_pc_unit;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] VEC = 10'h3FF;
`ifdef PC_UNIT_INTR_EN
    localparam bit INTR_ON = 1'b1;
`else
    localparam bit INTR_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pc_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    pc_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
        n_err = n_err + 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // reference model
    logic [AW-1:0] m_pc;
    logic          m_err;
    logic [AW-1:0] m_stk[$];

    task automatic model_reset();
        m_pc  = '0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_op(input logic [2:0] op, input logic [AW-1:0] imm, input logic clr);
        bit e;
        e = 1'b0;
        case (op)
            3'd1: m_pc = m_pc + 1'b1;
            3'd2: m_pc = imm;
            3'd3: if (m_stk.size() == DEPTH) e = 1'b1;
                  else begin m_stk.push_back(m_pc + 1'b1); m_pc = imm; end
            3'd4: if (m_stk.size() == 0) e = 1'b1;
                  else m_pc = m_stk.pop_back();
            3'd5: if (INTR_ON) begin
                      if (m_stk.size() == DEPTH) e = 1'b1;
                      else begin m_stk.push_back(m_pc); m_pc = VEC; end
                  end
            default: ;
        endcase
        if (e) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    32'(bus.pc_count),  32'(m_pc));
        check({tag, ".level"}, 32'(bus.stk_level), 32'(m_stk.size()));
        check({tag, ".full"},  32'(bus.stk_full),  32'(m_stk.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.stk_empty), 32'(m_stk.size() == 0));
        check({tag, ".err"},   32'(bus.stk_err),   32'(m_err));
    endtask

    // driver: present op, clock it in, compare 1 time unit after the edge
    task automatic step(input logic [2:0] op, input logic [AW-1:0] imm, input logic clr, input string tag);
        bus.pc_op       = op;
        bus.from_immed  = imm;
        bus.stk_err_clr = clr;
        model_op(op, imm, clr);
        @(posedge clk);
        #1;
        bus.pc_op       = 3'd0;
        bus.stk_err_clr = 1'b0;
        check_model(tag);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] imm;
        logic          clr;
        logic [AW-1:0] exp_pc;
        int            exp_level;
        logic          exp_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.pc_op       = 3'd0;
        bus.from_immed  = '0;
        bus.stk_err_clr = 1'b0;
        model_reset();

        tbl[0]  = '{3'd2, 10'h3FF, 1'b0, 10'h3FF, 0, 1'b0};
        tbl[1]  = '{3'd1, 10'h000, 1'b0, 10'h000, 0, 1'b0};
        tbl[2]  = '{3'd2, 10'h010, 1'b0, 10'h010, 0, 1'b0};
        tbl[3]  = '{3'd3, 10'h200, 1'b0, 10'h200, 1, 1'b0};
        tbl[4]  = '{3'd3, 10'h300, 1'b0, 10'h300, 2, 1'b0};
        tbl[5]  = '{3'd4, 10'h000, 1'b0, 10'h201, 1, 1'b0};
        tbl[6]  = '{3'd4, 10'h000, 1'b0, 10'h011, 0, 1'b0};
        tbl[7]  = '{3'd4, 10'h000, 1'b0, 10'h011, 0, 1'b1};
        tbl[8]  = '{3'd0, 10'h000, 1'b1, 10'h011, 0, 1'b0};
        tbl[9]  = '{3'd4, 10'h000, 1'b1, 10'h011, 0, 1'b1};
        tbl[10] = '{3'd0, 10'h000, 1'b1, 10'h011, 0, 1'b0};
        tbl[11] = '{3'd6, 10'h155, 1'b0, 10'h011, 0, 1'b0};
        tbl[12] = '{3'd7, 10'h2AA, 1'b0, 10'h011, 0, 1'b0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset.pc",    32'(bus.pc_count),  32'h0);
        check("reset.level", 32'(bus.stk_level), 32'h0);
        check("reset.empty", 32'(bus.stk_empty), 32'h1);
        check("reset.err",   32'(bus.stk_err),   32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.pc", 32'(bus.pc_count), 32'h0);

        // directed table: wrap, call/return, underflow and clear, reserved ops
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].op, tbl[i].imm, tbl[i].clr, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.exp_pc", i),    32'(bus.pc_count),  32'(tbl[i].exp_pc));
            check($sformatf("tbl%0d.exp_level", i), 32'(bus.stk_level), 32'(tbl[i].exp_level));
            check($sformatf("tbl%0d.exp_err", i),   32'(bus.stk_err),   32'(tbl[i].exp_err));
        end

        // overflow: fill, one extra call, then drain in reverse order
        step(3'd2, 10'h040, 1'b0, "ovf.jmp");
        for (int i = 0; i < DEPTH; i++) begin
            step(3'd3, AW'(10'h100 + i), 1'b0, $sformatf("ovf.call%0d", i));
        end
        check("ovf.full", 32'(bus.stk_full), 32'h1);
        step(3'd3, 10'h123, 1'b0, "ovf.call9");
        check("ovf.pc_hold", 32'(bus.pc_count), 32'h107);
        check("ovf.err",     32'(bus.stk_err),  32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            step(3'd4, '0, 1'b0, $sformatf("ovf.ret%0d", i));
            check($sformatf("ovf.ret%0d.addr", i), 32'(bus.pc_count),
                  (i == DEPTH - 1) ? 32'h041 : 32'(10'h107 - i));
        end
        check("ovf.empty", 32'(bus.stk_empty), 32'h1);
        step(3'd0, '0, 1'b1, "ovf.clr");

        // interrupt entry and return
        step(3'd2, 10'h044, 1'b0, "intr.jmp");
        step(3'd5, 10'h155, 1'b0, "intr.op");
        check("intr.pc",    32'(bus.pc_count),  INTR_ON ? 32'h3FF : 32'h044);
        check("intr.level", 32'(bus.stk_level), INTR_ON ? 32'h1 : 32'h0);
        step(3'd4, '0, 1'b0, "intr.ret");
        check("intr.ret_pc", 32'(bus.pc_count), 32'h044);
        step(3'd0, '0, 1'b1, "intr.clr");

        // asynchronous reset mid-cycle with non-trivial state
        step(3'd4, '0, 1'b0, "areset.err");
        step(3'd3, 10'h030, 1'b0, "areset.call");
        step(3'd2, 10'h05A, 1'b0, "areset.jmp");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset.pc",    32'(bus.pc_count),  32'h0);
        check("areset.level", 32'(bus.stk_level), 32'h0);
        check("areset.err",   32'(bus.stk_err),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset held across a CALL edge discards the push
        step(3'd2, 10'h0AB, 1'b0, "rcall.jmp");
        bus.pc_op      = 3'd3;
        bus.from_immed = 10'h2CC;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        bus.pc_op = 3'd0;
        model_reset();
        check_model("rcall");
        @(negedge clk);
        rst_n = 1'b1;
        step(3'd1, '0, 1'b0, "rcall.first_op");
        check("rcall.first_pc", 32'(bus.pc_count), 32'h1);

        // random ops against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            int r;
            r = $urandom_range(0, 15);
            if (r < 4)       op = 3'd3;
            else if (r < 8)  op = 3'd4;
            else if (r < 10) op = 3'd1;
            else if (r < 11) op = 3'd2;
            else if (r < 13) op = 3'd5;
            else             op = 3'($urandom_range(0, 7));
            step(op, AW'($urandom), ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter AW, default 10, program-counter and address width in bits (AW >= 4).
REQ-002 Parameter DEPTH, default 8, return-stack entries (power of two, >= 2).
REQ-003 Parameter INTR_VEC, default 'h3FF, interrupt vector address, truncated to AW bits.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low.
REQ-006 PC_OP  input  3  operation code: 0 HOLD, 1 INC, 2 JMP, 3 CALL, 4 RET, 5 INTR; 6 and 7 behave as HOLD.
REQ-007 FROM_IMMED  input  AW  jump and call target.
REQ-008 STK_ERR_CLR  input  1  clears the sticky error flag.
REQ-009 PC_COUNT  output  AW  registered program counter.
REQ-010 STK_LEVEL  output  $clog2(DEPTH)+1  number of occupied stack entries.
REQ-011 STK_FULL / STK_EMPTY  output  1 each  STK_LEVEL==DEPTH / STK_LEVEL==0, combinational from the level.
REQ-012 STK_ERR  output  1  sticky overflow/underflow flag.

Function
REQ-013 HOLD: PC_COUNT, stack and level unchanged.
REQ-014 INC: PC_COUNT <= PC_COUNT+1 modulo 2^AW; all-ones wraps to 0.
REQ-015 JMP: PC_COUNT <= FROM_IMMED.
REQ-016 CALL, not full: push (PC_COUNT+1) mod 2^AW, PC_COUNT <= FROM_IMMED, level +1, all on one edge.
REQ-017 RET, not empty: PC_COUNT <= top entry, level -1, on one edge; popped data visible on PC_COUNT after that edge.
REQ-018 INTR, not full: push current PC_COUNT (not +1), PC_COUNT <= INTR_VEC, level +1.
REQ-019 CALL or INTR while full: no push, PC_COUNT unchanged, STK_ERR <= 1.
REQ-020 RET while empty: PC_COUNT unchanged, STK_ERR <= 1.
REQ-021 STK_ERR_CLR and a new error in the same cycle: the error wins, STK_ERR stays 1.
REQ-022 Stack is LIFO; an entry pushed then popped is returned bit-exact; entries above the level are don't-care.
REQ-023 Latency: every op takes effect at the first rising edge after it is presented; one op per cycle, no stalls.

Reset
REQ-024 RST_N low asynchronously forces PC_COUNT=0, STK_LEVEL=0, STK_ERR=0 and an idle state, independent of CLK.
REQ-025 Reset asserted mid-sequence (e.g. during a CALL edge) discards the op; no partial push survives.
REQ-026 Stack storage contents need not be reset; only pointer and level are reset.
REQ-027 After RST_N deasserts, the first op is honoured at the next rising edge.

Configuration
REQ-028 Macro PC_UNIT_INTR_EN defined: op 5 (INTR) behaves per REQ-018/019.
REQ-029 Macro PC_UNIT_INTR_EN undefined: op 5 behaves as HOLD, INTR_VEC is unused, and no interrupt logic is synthesised.

Structure
REQ-030 Shared package pc_unit_pkg holds the PC_OP enumeration (typedef, 3 bits) and the default vector constant.
REQ-031 Return stack is one sub-module pc_ret_stack (parameters AW, DEPTH; push, pop, data in/out, level, full, empty).
REQ-032 pc_unit contains the next-PC select, the PC register and the error flag; pc_ret_stack contains storage and the pointer.

Verification
REQ-033 Reset: RST_N low mid-cycle with PC_COUNT=0x05A -> PC_COUNT=0, STK_LEVEL=0, STK_ERR=0 without waiting for a clock edge.
REQ-034 Wrap: JMP 0x3FF, then INC -> PC_COUNT 0x3FF, then 0x000.
REQ-035 Call/return: PC=0x010, CALL 0x200, CALL 0x300, RET, RET -> PC 0x200, 0x300, 0x201, 0x011; level 1,2,1,0.
REQ-036 Overflow: 8 CALLs fill the stack (FULL=1), 9th CALL 0x123 -> PC unchanged, ERR=1; 8 RETs return addresses in reverse order.
REQ-037 Underflow and clear: RET while empty -> PC unchanged, ERR=1; STK_ERR_CLR asserted together with a RET while empty -> ERR remains 1; STK_ERR_CLR alone -> ERR=0.
REQ-038 Interrupt (PC_UNIT_INTR_EN defined): PC=0x044, INTR -> PC 0x3FF, level 1; RET -> PC 0x044. Macro undefined: INTR -> PC stays 0x044, level 0.
